// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset/lock sequencer with lock debounce, timeout retry and system reset hold
module pll_lock_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int CW    = $clog2(MAX_C);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          lost_q, lost_d;
  logic          sync1_q, sync2_q;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_reset_q, sys_reset_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          lock_s;

  assign lock_s = sync2_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (restart) begin
      state_d = S_HOLD;
      retry_d = 4'd0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // A lock seen on the final timeout cycle still wins over the retry.
          if (lock_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = S_HOLD;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            lost_d  = 1'b1;
            retry_d = 4'd0;
            state_d = S_HOLD;
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_HOLD;
      endcase
    end

    // Restart re-arms the counter even when already in HOLD so a full hold follows.
    if (restart || (state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAIL))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    pll_reset_d = (state_d == S_HOLD) || (state_d == S_FAIL);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      lost_q      <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync1_q     <= pll_lock;
      sync2_q     <= sync1_q;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - directed scoreboard bench for pll_lock_seq
module tb_pll_lock_seq;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  pll_lock_seq #(
    .RST_CYCLES  (4),
    .LOCK_TIMEOUT(16),
    .LOCK_STABLE (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .sys_reset(sys_reset),
    .ready    (ready),
    .fail     (fail),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         at;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   edge_n;
  int   checks;
  int   errors;

  // {pll_reset, sys_reset, ready, fail, lock_lost, retry_cnt}
  function automatic logic [8:0] o_hold(logic lost, logic [3:0] r);
    return {1'b1, 1'b1, 1'b0, 1'b0, lost, r};
  endfunction
  function automatic logic [8:0] o_wait(logic lost, logic [3:0] r);
    return {1'b0, 1'b1, 1'b0, 1'b0, lost, r};
  endfunction
  function automatic logic [8:0] o_run(logic lost, logic [3:0] r);
    return {1'b0, 1'b0, 1'b1, 1'b0, lost, r};
  endfunction
  function automatic logic [8:0] o_fail(logic lost, logic [3:0] r);
    return {1'b1, 1'b1, 1'b0, 1'b1, lost, r};
  endfunction

  task automatic expect_at(input string tag, input int at, input logic [8:0] v);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t       e;
    logic [8:0] obs;
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      e   = sb.pop_front();
      obs = {pll_reset, sys_reset, ready, fail, lock_lost, retry_cnt};
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s edge %0d observed %b expected %b", e.tag, edge_n, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    check_due();
  endtask

  task automatic run_until(input int n);
    while (edge_n < n) tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    edge_n   = 0;
    reset    = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_at("reset_state", edge_n, o_hold(1'b0, 4'd0));
    check_due();
    reset  = 1'b0;
    edge_n = 0;

    // nominal
    expect_at("nom_hold_e1", 1, o_hold(1'b0, 4'd0));
    expect_at("nom_hold_e3", 3, o_hold(1'b0, 4'd0));
    expect_at("nom_pllrst_fall_e4", 4, o_wait(1'b0, 4'd0));
    expect_at("nom_wait_e11", 11, o_wait(1'b0, 4'd0));
    expect_at("nom_stable_e19", 19, o_wait(1'b0, 4'd0));
    expect_at("nom_ready_e20", 20, o_run(1'b0, 4'd0));
    run_until(9);
    pll_lock = 1'b1;
    run_until(20);

    // lock loss and re-lock
    expect_at("loss_run_e25", 25, o_run(1'b0, 4'd0));
    expect_at("loss_k1", 27, o_run(1'b0, 4'd0));
    expect_at("loss_k2", 28, o_hold(1'b1, 4'd0));
    expect_at("loss_wait", 32, o_wait(1'b1, 4'd0));
    expect_at("loss_stable_last", 40, o_wait(1'b1, 4'd0));
    expect_at("loss_relock_ready", 41, o_run(1'b1, 4'd0));
    run_until(25);
    pll_lock = 1'b0;
    run_until(29);
    pll_lock = 1'b1;
    run_until(45);

    // restart from RUN
    restart = 1'b1;
    expect_at("rst_run_hold", 46, o_hold(1'b0, 4'd0));
    expect_at("rst_run_hold_end", 49, o_hold(1'b0, 4'd0));
    expect_at("rst_run_wait", 50, o_wait(1'b0, 4'd0));
    expect_at("rst_run_stable", 58, o_wait(1'b0, 4'd0));
    expect_at("rst_run_ready", 59, o_run(1'b0, 4'd0));
    tick();
    restart = 1'b0;
    run_until(62);

    // debounce: one-cycle drop on the 5th stable cycle
    restart  = 1'b1;
    pll_lock = 1'b0;
    expect_at("deb_hold", 63, o_hold(1'b0, 4'd0));
    expect_at("deb_wait", 67, o_wait(1'b0, 4'd0));
    expect_at("deb_stable", 77, o_wait(1'b0, 4'd0));
    expect_at("deb_no_early_ready", 80, o_wait(1'b0, 4'd0));
    expect_at("deb_stable_last", 86, o_wait(1'b0, 4'd0));
    expect_at("deb_ready", 87, o_run(1'b0, 4'd0));
    tick();
    restart = 1'b0;
    run_until(69);
    pll_lock = 1'b1;
    run_until(75);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    run_until(90);

    // timeout to FAIL
    restart  = 1'b1;
    pll_lock = 1'b0;
    expect_at("to_hold", 94, o_hold(1'b0, 4'd0));
    expect_at("to_wait1", 95, o_wait(1'b0, 4'd0));
    expect_at("to_wait1_last", 110, o_wait(1'b0, 4'd0));
    expect_at("to_retry1", 111, o_hold(1'b0, 4'd1));
    expect_at("to_wait2", 115, o_wait(1'b0, 4'd1));
    expect_at("to_retry2", 131, o_hold(1'b0, 4'd2));
    expect_at("to_wait3", 135, o_wait(1'b0, 4'd2));
    expect_at("to_wait3_last", 150, o_wait(1'b0, 4'd2));
    expect_at("to_fail", 151, o_fail(1'b0, 4'd2));
    expect_at("to_fail_stays", 200, o_fail(1'b0, 4'd2));
    tick();
    restart = 1'b0;
    run_until(205);

    // restart from FAIL
    restart  = 1'b1;
    pll_lock = 1'b1;
    expect_at("rst_fail_hold", 206, o_hold(1'b0, 4'd0));
    expect_at("rst_fail_wait", 210, o_wait(1'b0, 4'd0));
    expect_at("rst_fail_ready", 219, o_run(1'b0, 4'd0));
    tick();
    restart = 1'b0;
    run_until(222);

    // async reset in RUN
    #3;
    reset = 1'b1;
    #1;
    expect_at("areset_run", edge_n, o_hold(1'b0, 4'd0));
    check_due();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;

    // async reset in STABLE
    expect_at("post_reset_hold", 3, o_hold(1'b0, 4'd0));
    expect_at("post_reset_wait", 4, o_wait(1'b0, 4'd0));
    expect_at("post_reset_stable", 7, o_wait(1'b0, 4'd0));
    run_until(7);
    #3;
    reset = 1'b1;
    #1;
    expect_at("areset_stable", edge_n, o_hold(1'b0, 4'd0));
    check_due();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;
    expect_at("final_hold", 2, o_hold(1'b0, 4'd0));
    run_until(2);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain pending %0d required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
